// File: rtl/cpu_control.sv
// Purpose : sequential control unit for a small 10-bit CPU (fetch/decode/execute/writeback, R0..R3, external ALU).
// Latency : 4 cycles per instruction with a ready instruction memory; each FETCH cycle without imem_valid adds one.
// Backpressure: FETCH waits indefinitely on imem_valid; no other handshakes, HALTED is left only by reset.
//
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   imem_req/imem_addr           - fetch request and address (address is pc)
//   imem_valid/imem_rdata        - fetch response, only looked at in FETCH
//   alu_a/alu_b/alu_ctrl         - registered operands and operation (IR[9:7]) to the external ALU
//   alu_result/alu_halt          - combinational ALU outputs, captured in EXECUTE
//   pc, retired, halted          - program counter, per-instruction retire pulse, stopped flag
//   dbg_sel/dbg_data             - combinational register-file read port
module cpu_control (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [9:0]  imem_addr,
    input  logic        imem_valid,
    input  logic [9:0]  imem_rdata,
    output logic [9:0]  alu_a,
    output logic [9:0]  alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [9:0]  alu_result,
    input  logic        alu_halt,
    output logic [9:0]  pc,
    output logic        retired,
    output logic        halted,
    input  logic [1:0]  dbg_sel,
    output logic [9:0]  dbg_data
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALTED
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [9:0]  ir;
    logic [9:0]  op_a;
    logic [9:0]  op_b;
    logic [9:0]  res;
    logic        hlt;
    logic [9:0]  r1;
    logic [9:0]  r2;
    logic [9:0]  r3;

    // Read view of the register file; R0 is hard-wired to zero.
    logic [9:0]  rf [4];
    assign rf[0] = '0;
    assign rf[1] = r1;
    assign rf[2] = r2;
    assign rf[3] = r3;

    logic [1:0]  rd_idx;
    logic [1:0]  rs_idx;
    assign rd_idx = ir[6:5];
    assign rs_idx = ir[4:3];

    // IR[2:0] carry no meaning in this instruction set.
    logic        unused_ir_bits;
    assign unused_ir_bits = ^ir[2:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:     if (imem_valid) state_nxt = S_DECODE;
            S_DECODE:    state_nxt = S_EXECUTE;
            S_EXECUTE:   state_nxt = S_WRITEBACK;
            S_WRITEBACK: state_nxt = hlt ? S_HALTED : S_FETCH;
            S_HALTED:    state_nxt = S_HALTED;
            default:     state_nxt = S_FETCH;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc   <= '0;
            ir   <= '0;
            op_a <= '0;
            op_b <= '0;
            res  <= '0;
            hlt  <= 1'b0;
            r1   <= '0;
            r2   <= '0;
            r3   <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_valid) ir <= imem_rdata;
                end
                S_DECODE: begin
                    // Writeback of the previous instruction has already landed, so no bypass is needed.
                    op_a <= rf[rd_idx];
                    op_b <= rf[rs_idx];
                end
                S_EXECUTE: begin
                    res <= alu_result;
                    hlt <= alu_halt;
                end
                S_WRITEBACK: begin
                    if (!hlt) begin
                        pc <= pc + 10'd1;   // wraps 1023 -> 0
                        case (rd_idx)
                            2'd1:    r1 <= res;
                            2'd2:    r2 <= res;
                            2'd3:    r3 <= res;
                            default: ;      // writes to R0 are dropped
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs. Status strobes are masked while reset is held so an in-flight
    // instruction never reports completion in the cycle it is being discarded.
    assign imem_req  = (state == S_FETCH) || reset;
    assign imem_addr = pc;
    assign alu_a     = op_a;
    assign alu_b     = op_b;
    assign alu_ctrl  = ir[9:7];
    assign retired   = (state == S_WRITEBACK) && !hlt && !reset;
    assign halted    = (state == S_HALTED) && !reset;
    assign dbg_data  = rf[dbg_sel];

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control with a behavioural ALU and instruction memory.
// ALU opcodes: 0 ADD, 1 SUB, 2 AND, 3 NAND, 4 OR, 5 SLL, 6 HALT, 7 XOR.
// Outputs are sampled 1 time unit after each rising edge.
module tb_cpu_control;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_valid;
    logic [9:0]  imem_rdata;
    logic [9:0]  alu_a;
    logic [9:0]  alu_b;
    logic [2:0]  alu_ctrl;
    logic [9:0]  alu_result;
    logic        alu_halt;
    logic [9:0]  pc;
    logic        retired;
    logic        halted;
    logic [1:0]  dbg_sel;
    logic [9:0]  dbg_data;

    int          vectors;
    int          miscompares;

    logic [9:0]  mem [1024];
    logic        use_mem;
    logic [9:0]  rand_data;

    cpu_control dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_halt   (alu_halt),
        .pc         (pc),
        .retired    (retired),
        .halted     (halted),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rdata = use_mem ? mem[imem_addr] : rand_data;

    always_comb begin
        alu_result = '0;
        alu_halt   = 1'b0;
        case (alu_ctrl)
            3'd0: alu_result = alu_a + alu_b;
            3'd1: alu_result = alu_a - alu_b;
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = ~(alu_a & alu_b);
            3'd4: alu_result = alu_a | alu_b;
            3'd5: alu_result = {alu_a[8:0], 1'b0};
            3'd6: alu_halt   = 1'b1;
            3'd7: alu_result = alu_a ^ alu_b;
            default: ;
        endcase
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] sel, input logic [9:0] exp);
        dbg_sel = sel;
        #0;
        chk(tag, {6'd0, dbg_data}, {6'd0, exp});
    endtask

    int nret;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        imem_valid  = 1'b1;
        use_mem     = 1'b1;
        rand_data   = '0;
        dbg_sel     = 2'd1;
        for (int i = 0; i < 1024; i++) mem[i] = 10'h000;
        mem[0] = 10'h1A8;   // NAND R1,R1
        mem[1] = 10'h2A8;   // SLL  R1,R1
        mem[2] = 10'h300;   // HALT

        // Reset values
        step(2);
        chk("rst_imem_req",  {15'd0, imem_req}, 16'd1);
        chk("rst_imem_addr", {6'd0, imem_addr}, 16'd0);
        chk("rst_retired",   {15'd0, retired},  16'd0);
        chk("rst_halted",    {15'd0, halted},   16'd0);
        chk("rst_alu_ctrl",  {13'd0, alu_ctrl}, 16'd0);
        chk("rst_alu_a",     {6'd0, alu_a},     16'd0);
        chk("rst_alu_b",     {6'd0, alu_b},     16'd0);
        reset = 1'b0;

        // Three-instruction program; now in cycle 1
        chk("c1_imem_req", {15'd0, imem_req}, 16'd1);
        step(1);                                            // cycle 2 DECODE
        chk("c2_alu_ctrl", {13'd0, alu_ctrl}, 16'd3);
        step(1);                                            // cycle 3 EXECUTE
        chk("c3_alu_a", {6'd0, alu_a}, 16'd0);
        step(1);                                            // cycle 4 WRITEBACK
        chk("c4_retired", {15'd0, retired}, 16'd1);
        rd_chk("c4_r1_old", 2'd1, 10'h000);
        step(1);                                            // cycle 5
        rd_chk("c5_r1", 2'd1, 10'h3FF);
        chk("c5_pc", {6'd0, pc}, 16'd1);
        chk("c5_retired", {15'd0, retired}, 16'd0);
        step(2);                                            // cycle 7 EXECUTE of SLL
        chk("c7_alu_a", {6'd0, alu_a}, 16'h3FF);
        step(1);                                            // cycle 8
        chk("c8_retired", {15'd0, retired}, 16'd1);
        chk("c8_alu_ctrl", {13'd0, alu_ctrl}, 16'd5);
        step(1);                                            // cycle 9
        rd_chk("c9_r1", 2'd1, 10'h3FE);
        chk("c9_pc", {6'd0, pc}, 16'd2);
        step(3);                                            // cycle 12 WB of HALT
        chk("c12_retired", {15'd0, retired}, 16'd0);
        chk("c12_halted", {15'd0, halted}, 16'd0);
        step(1);                                            // cycle 13
        chk("c13_halted", {15'd0, halted}, 16'd1);
        chk("c13_imem_req", {15'd0, imem_req}, 16'd0);
        chk("c13_pc", {6'd0, pc}, 16'd2);

        // HALTED ignores memory traffic
        use_mem = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rand_data = 10'($urandom);
            step(1);
            chk("halt_hold", {15'd0, halted}, 16'd1);
        end
        chk("halt_pc", {6'd0, pc}, 16'd2);
        rd_chk("halt_r1", 2'd1, 10'h3FE);
        use_mem = 1'b1;

        // Reset out of HALTED restarts at address 0
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("restart_addr", {6'd0, imem_addr}, 16'd0);
        chk("restart_req", {15'd0, imem_req}, 16'd1);
        chk("restart_halted", {15'd0, halted}, 16'd0);
        rd_chk("restart_r1", 2'd1, 10'h000);

        // Reset during EXECUTE of SLL R1 with R1=0x3FF
        step(6);                                            // cycle 7
        rd_chk("mid_r1", 2'd1, 10'h3FF);
        chk("mid_pc", {6'd0, pc}, 16'd1);
        chk("mid_alu_ctrl", {13'd0, alu_ctrl}, 16'd5);
        reset = 1'b1;
        mem[0] = 10'h188;                                   // NAND R0,R1
        step(1);
        chk("abort_retired", {15'd0, retired}, 16'd0);
        rd_chk("abort_r1", 2'd1, 10'h000);
        chk("abort_pc", {6'd0, pc}, 16'd0);
        chk("abort_req", {15'd0, imem_req}, 16'd1);
        chk("abort_alu_ctrl", {13'd0, alu_ctrl}, 16'd0);
        reset = 1'b0;

        // Write to R0 is discarded but still retires
        step(3);                                            // cycle 4
        chk("r0_retired", {15'd0, retired}, 16'd1);
        step(1);
        rd_chk("r0_read", 2'd0, 10'h000);
        rd_chk("r0_r1", 2'd1, 10'h000);
        chk("r0_pc", {6'd0, pc}, 16'd1);

        // FETCH stall of 5 cycles
        reset = 1'b1;
        mem[0] = 10'h1A8;
        imem_valid = 1'b0;
        step(1);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_req", {15'd0, imem_req}, 16'd1);
            chk("stall_ir", {13'd0, alu_ctrl}, 16'd0);
            step(1);
        end
        imem_valid = 1'b1;                                  // cycle 6
        step(2);                                            // cycle 8
        chk("stall_c8_retired", {15'd0, retired}, 16'd0);
        step(1);                                            // cycle 9
        chk("stall_c9_retired", {15'd0, retired}, 16'd1);
        step(1);
        chk("stall_pc", {6'd0, pc}, 16'd1);
        rd_chk("stall_r1", 2'd1, 10'h3FF);

        // pc wrap with a NOP stream
        reset = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = 10'h000;
        step(1);
        reset = 1'b0;
        nret = 0;
        for (int k = 0; k < 4092; k++) begin
            if (retired) nret++;
            step(1);
        end
        chk("wrap_retire_count", 16'(nret), 16'd1023);
        chk("wrap_pc_1023", {6'd0, pc}, 16'd1023);
        chk("wrap_addr_1023", {6'd0, imem_addr}, 16'd1023);
        step(3);
        chk("wrap_retired", {15'd0, retired}, 16'd1);
        step(1);
        chk("wrap_pc_0", {6'd0, pc}, 16'd0);
        chk("wrap_addr_0", {6'd0, imem_addr}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
